// File: rtl/rv16_fu_pkg.sv
// Shared types and helpers for the rv16 execute-stage issue controller.
// Opcode encoding, FU indices, unit FSM states and latency/legality lookups.
package rv16_fu_pkg;

    localparam int FU_N = 7;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6
    } op_e;

    localparam int FU_ADD = 0;
    localparam int FU_SUB = 1;
    localparam int FU_MUL = 2;
    localparam int FU_DIV = 3;
    localparam int FU_XOR = 4;
    localparam int FU_AND = 5;
    localparam int FU_OR  = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } unit_st_e;

    function automatic logic op_legal(input int op);
        return (op >= 0) && (op < FU_N);
    endfunction

    function automatic int op_latency(input int op, input int mul_lat, input int div_lat);
        case (op)
            FU_MUL:  return mul_lat;
            FU_DIV:  return div_lat;
            default: return 1;
        endcase
    endfunction

    function automatic logic [FU_N-1:0] fu_onehot(input int op);
        return FU_N'(1) << op;
    endfunction

endpackage

// File: rtl/rv16_fu_issue_ctrl_if.sv
// Decoded-op handshake, issue strobes and writeback bundle of rv16_fu_issue_ctrl.
// Perf counter signals exist only when RV16_ISSUE_PERF_EN is defined.
interface rv16_fu_issue_ctrl_if #(
    parameter int OPCODE = 4,
    parameter int RD     = 3
);
    logic                          in_valid;
    logic                          in_ready;
    logic [OPCODE-1:0]             in_opcode;
    logic [RD-1:0]                 in_rd;
    logic                          issue_valid;
    logic [rv16_fu_pkg::FU_N-1:0]  issue_onehot;
    logic [OPCODE-1:0]             issue_opcode;
    logic                          wb_valid;
    logic [rv16_fu_pkg::FU_N-1:0]  wb_sel;
    logic [RD-1:0]                 wb_rd;
    logic                          illegal_op;
    logic                          mul_busy;
    logic                          div_busy;
`ifdef RV16_ISSUE_PERF_EN
    logic [15:0]                   perf_stall_cnt;
    logic [15:0]                   perf_issue_cnt;
`endif

    modport slave (
`ifdef RV16_ISSUE_PERF_EN
        output perf_stall_cnt, perf_issue_cnt,
`endif
        input  in_valid, in_opcode, in_rd,
        output in_ready, issue_valid, issue_onehot, issue_opcode,
        output wb_valid, wb_sel, wb_rd, illegal_op, mul_busy, div_busy
    );

    modport master (
`ifdef RV16_ISSUE_PERF_EN
        input  perf_stall_cnt, perf_issue_cnt,
`endif
        output in_valid, in_opcode, in_rd,
        input  in_ready, issue_valid, issue_onehot, issue_opcode,
        input  wb_valid, wb_sel, wb_rd, illegal_op, mul_busy, div_busy
    );

endinterface

// File: rtl/rv16_fu_busy_tracker.sv
// Occupancy tracker for one non-pipelined unit (MUL or DIV): IDLE/BUSY FSM plus down-counter.
// Goes idle in the unit's writeback cycle so the next op can be accepted in that same cycle.
module rv16_fu_busy_tracker
    import rv16_fu_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o
);

    unit_st_e   state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = 4'(LAT - 1);
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue is registered on the acceptance edge, so the accepted-not-issued window is empty.
    assign busy_o = (state_q == ST_BUSY);

endmodule

// File: rtl/rv16_fu_issue_ctrl.sv
// rv16 execute-stage issue scheduler: valid/ready intake, one-hot FU issue, writeback-port reservation ring.
// Optional RV16_ISSUE_PERF_EN adds saturating stall/issue counters.
module rv16_fu_issue_ctrl
    import rv16_fu_pkg::*;
#(
    parameter int OPCODE  = 4,
    parameter int RD      = 3,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst,
    rv16_fu_issue_ctrl_if.slave bus
);

    localparam int RING_N = DIV_LAT + 2;

    logic [RING_N-1:0] ring_vld_q, ring_vld_d;
    logic [FU_N-1:0]   ring_sel_q [RING_N];
    logic [FU_N-1:0]   ring_sel_d [RING_N];
    logic [RD-1:0]     ring_rd_q  [RING_N];
    logic [RD-1:0]     ring_rd_d  [RING_N];

    logic              issue_valid_q;
    logic [FU_N-1:0]   issue_onehot_q;
    logic [OPCODE-1:0] issue_opcode_q;
    logic              illegal_q;

    int                opc;
    int                lat;
    logic              legal, slot_free, unit_free, in_ready, accept, issue_go;
    logic              mul_busy, div_busy;
    logic [RING_N-1:0] vld_at_slot;

    always_comb begin
        opc         = int'(bus.in_opcode);
        legal       = op_legal(opc);
        lat         = op_latency(opc, MUL_LAT, DIV_LAT);
        vld_at_slot = ring_vld_q >> (lat + 1);
        slot_free   = ~vld_at_slot[0];
        unit_free   = !((opc == FU_MUL && mul_busy) || (opc == FU_DIV && div_busy));
        in_ready    = !rst && (!legal || (slot_free && unit_free));
        accept      = bus.in_valid && in_ready;
        issue_go    = accept && legal;
    end

    // Ring advances every cycle; a new op lands where it reaches entry 0 exactly L cycles after issue.
    always_comb begin
        ring_vld_d = ring_vld_q >> 1;
        for (int i = 0; i < RING_N - 1; i++) begin
            ring_sel_d[i] = ring_sel_q[i+1];
            ring_rd_d[i]  = ring_rd_q[i+1];
        end
        ring_sel_d[RING_N-1] = '0;
        ring_rd_d[RING_N-1]  = '0;
        if (issue_go) begin
            ring_vld_d = ring_vld_d | (RING_N'(1) << lat);
            for (int i = 0; i < RING_N; i++) begin
                if (i == lat) begin
                    ring_sel_d[i] = fu_onehot(opc);
                    ring_rd_d[i]  = bus.in_rd;
                end
            end
        end
    end

    // NOTE: the ring is reset, not just its valid bits, so a reset drops every in-flight writeback cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_vld_q     <= '0;
            issue_valid_q  <= 1'b0;
            issue_onehot_q <= '0;
            issue_opcode_q <= '0;
            illegal_q      <= 1'b0;
            for (int i = 0; i < RING_N; i++) begin
                ring_sel_q[i] <= '0;
                ring_rd_q[i]  <= '0;
            end
        end else begin
            ring_vld_q     <= ring_vld_d;
            issue_valid_q  <= issue_go;
            issue_onehot_q <= issue_go ? fu_onehot(opc) : '0;
            issue_opcode_q <= issue_go ? bus.in_opcode : '0;
            illegal_q      <= accept && !legal;
            for (int i = 0; i < RING_N; i++) begin
                ring_sel_q[i] <= ring_sel_d[i];
                ring_rd_q[i]  <= ring_rd_d[i];
            end
        end
    end

    rv16_fu_busy_tracker #(.LAT(MUL_LAT)) u_mul_busy (
        .clk     (clk),
        .rst     (rst),
        .start_i (issue_go && opc == FU_MUL),
        .busy_o  (mul_busy)
    );

    rv16_fu_busy_tracker #(.LAT(DIV_LAT)) u_div_busy (
        .clk     (clk),
        .rst     (rst),
        .start_i (issue_go && opc == FU_DIV),
        .busy_o  (div_busy)
    );

    assign bus.in_ready     = in_ready;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_onehot = issue_onehot_q;
    assign bus.issue_opcode = issue_opcode_q;
    assign bus.wb_valid     = ring_vld_q[0];
    assign bus.wb_sel       = ring_sel_q[0];
    assign bus.wb_rd        = ring_rd_q[0];
    assign bus.illegal_op   = illegal_q;
    assign bus.mul_busy     = mul_busy;
    assign bus.div_busy     = div_busy;

`ifdef RV16_ISSUE_PERF_EN
    logic [15:0] perf_stall_q, perf_issue_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_issue_q <= '0;
        end else begin
            if (bus.in_valid && !in_ready && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'd1;
            if (issue_valid_q && perf_issue_q != 16'hFFFF)
                perf_issue_q <= perf_issue_q + 16'd1;
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_issue_cnt = perf_issue_q;
`endif

endmodule

// File: tb/tb_rv16_fu_issue_ctrl.sv
// Directed self-checking bench for rv16_fu_issue_ctrl (MUL_LAT=3, DIV_LAT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_rv16_fu_issue_ctrl;
    import rv16_fu_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    rv16_fu_issue_ctrl_if #(.OPCODE(4), .RD(3)) bus ();

    rv16_fu_issue_ctrl #(
        .OPCODE  (4),
        .RD      (3),
        .MUL_LAT (3),
        .DIV_LAT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wb_obs();
        return 32'({bus.wb_valid, bus.wb_sel, bus.wb_rd});
    endfunction

    function automatic logic [31:0] wb_exp(input logic v, input logic [6:0] sel, input logic [2:0] rd);
        return 32'({v, sel, rd});
    endfunction

    function automatic logic [31:0] issue_obs();
        return 32'({bus.issue_valid, bus.issue_onehot, bus.issue_opcode});
    endfunction

    function automatic logic [31:0] issue_exp(input logic v, input logic [6:0] oh, input logic [3:0] op);
        return 32'({v, oh, op});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd);
        bus.in_valid  = v;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [6:0] logic_oh [3];

    initial begin
        logic_oh[0] = 7'b0010000;
        logic_oh[1] = 7'b0100000;
        logic_oh[2] = 7'b1000000;

        // Reset held two cycles, then released with nothing offered
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = 4'd0;
        bus.in_rd     = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue", issue_obs(), 32'd0);
        check("rst_wb", wb_obs(), 32'd0);
        check("rst_illegal", 32'(bus.illegal_op), 32'd0);
        check("rst_busy", 32'({bus.mul_busy, bus.div_busy}), 32'd0);
`ifdef RV16_ISSUE_PERF_EN
        check("rst_perf", 32'({bus.perf_stall_cnt, bus.perf_issue_cnt}), 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_quiet", 32'({bus.issue_valid, bus.wb_valid, bus.illegal_op}), 32'd0);
        end

        // ADD rd1 then SUB rd2 back to back
        do_reset();
        drive(1'b1, OP_ADD, 3'd1);
        check("s2_rdy0", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, OP_SUB, 3'd2);
        check("s2_rdy1", 32'(bus.in_ready), 32'd1);
        check("s2_iss1", issue_obs(), issue_exp(1'b1, 7'b0000001, 4'd0));
        tick();
        drive(1'b0, OP_ADD, 3'd0);
        check("s2_iss2", issue_obs(), issue_exp(1'b1, 7'b0000010, 4'd1));
        check("s2_wb2", wb_obs(), wb_exp(1'b1, 7'b0000001, 3'd1));
        tick();
        check("s2_iss3", issue_obs(), 32'd0);
        check("s2_wb3", wb_obs(), wb_exp(1'b1, 7'b0000010, 3'd2));
        tick();
        check("s2_wb4", wb_obs(), 32'd0);

        // MUL holds writeback slot c4, so ADD offered at c2 stalls once
        do_reset();
        drive(1'b1, OP_MUL, 3'd3);
        check("s3_rdy0", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, OP_ADD, 3'd0);
        check("s3_iss1", issue_obs(), issue_exp(1'b1, 7'b0000100, 4'd2));
        check("s3_mulbusy1", 32'(bus.mul_busy), 32'd1);
        tick();
        drive(1'b1, OP_ADD, 3'd4);
        check("s3_rdy2", 32'(bus.in_ready), 32'd0);
        tick();
        check("s3_rdy3", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, OP_ADD, 3'd0);
        check("s3_wb4", wb_obs(), wb_exp(1'b1, 7'b0000100, 3'd3));
        check("s3_iss4", issue_obs(), issue_exp(1'b1, 7'b0000001, 4'd0));
        tick();
        check("s3_wb5", wb_obs(), wb_exp(1'b1, 7'b0000001, 3'd4));
        tick();
        check("s3_wb6", wb_obs(), 32'd0);
`ifdef RV16_ISSUE_PERF_EN
        check("s3_perf_stall", 32'(bus.perf_stall_cnt), 32'd1);
        check("s3_perf_issue", 32'(bus.perf_issue_cnt), 32'd2);
`endif

        // Second MUL waits for the first MUL's writeback cycle
        do_reset();
        drive(1'b1, OP_MUL, 3'd1);
        check("s4_rdy0", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, OP_MUL, 3'd2);
        for (int k = 1; k <= 3; k++) begin
            check("s4_stall_rdy", 32'(bus.in_ready), 32'd0);
            check("s4_busy_first", 32'(bus.mul_busy), 32'd1);
            tick();
        end
        check("s4_rdy4", 32'(bus.in_ready), 32'd1);
        check("s4_busy4", 32'(bus.mul_busy), 32'd0);
        check("s4_wb4", wb_obs(), wb_exp(1'b1, 7'b0000100, 3'd1));
        tick();
        drive(1'b0, OP_ADD, 3'd0);
        for (int k = 5; k <= 7; k++) begin
            check("s4_busy_second", 32'(bus.mul_busy), 32'd1);
            check("s4_wb_quiet", 32'(bus.wb_valid), 32'd0);
            tick();
        end
        check("s4_busy8", 32'(bus.mul_busy), 32'd0);
        check("s4_wb8", wb_obs(), wb_exp(1'b1, 7'b0000100, 3'd2));

        // DIV rd7 at c0, then an ADD offered every cycle; only c7 collides (slot c9)
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            if (k == 0)      drive(1'b1, OP_DIV, 3'd7);
            else if (k <= 8) drive(1'b1, OP_ADD, (k <= 7) ? 3'(k) : 3'd7);
            else             drive(1'b0, OP_ADD, 3'd0);
            if (k <= 8)
                check($sformatf("s5_rdy_c%0d", k), 32'(bus.in_ready), (k == 7) ? 32'd0 : 32'd1);
            if (k >= 3 && k <= 8)
                check($sformatf("s5_wb_c%0d", k), wb_obs(), wb_exp(1'b1, 7'b0000001, 3'(k - 2)));
            else if (k == 9)
                check("s5_wb_c9", wb_obs(), wb_exp(1'b1, 7'b0001000, 3'd7));
            else if (k == 10)
                check("s5_wb_c10", wb_obs(), wb_exp(1'b1, 7'b0000001, 3'd7));
            else
                check($sformatf("s5_wb_c%0d", k), wb_obs(), 32'd0);
            if (k == 1 || k == 8) check($sformatf("s5_divbusy_c%0d", k), 32'(bus.div_busy), 32'd1);
            if (k == 9)           check("s5_divbusy_c9", 32'(bus.div_busy), 32'd0);
            tick();
        end

        // XOR, AND, OR back to back
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            if (k < 3) drive(1'b1, 4'(4 + k), 3'(k + 1));
            else       drive(1'b0, OP_ADD, 3'd0);
            if (k < 3) check("s7_rdy", 32'(bus.in_ready), 32'd1);
            if (k >= 1 && k <= 3)
                check($sformatf("s7_iss_c%0d", k), issue_obs(), issue_exp(1'b1, logic_oh[k-1], 4'(3 + k)));
            if (k >= 2)
                check($sformatf("s7_wb_c%0d", k), wb_obs(), wb_exp(1'b1, logic_oh[k-2], 3'(k - 1)));
            tick();
        end

        // Illegal opcode: pulse only, no issue, no writeback
        do_reset();
        drive(1'b1, 4'hA, 3'd5);
        check("s6_ill_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, OP_ADD, 3'd0);
        check("s6_ill_pulse", 32'(bus.illegal_op), 32'd1);
        check("s6_ill_noiss", 32'(bus.issue_valid), 32'd0);
        tick();
        check("s6_ill_done", 32'(bus.illegal_op), 32'd0);
        check("s6_ill_nowb", 32'(bus.wb_valid), 32'd0);

        // Illegal opcode stays ready behind a busy DIV; reset mid-DIV drops its writeback
        do_reset();
        drive(1'b1, OP_DIV, 3'd3);
        check("s6_div_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b1, 4'hF, 3'd0);
        check("s6_div_busy", 32'(bus.div_busy), 32'd1);
        check("s6_ill_rdy_busy", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, OP_ADD, 3'd0);
        check("s6_ill_pulse2", 32'(bus.illegal_op), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("s6_rst_divbusy", 32'(bus.div_busy), 32'd0);
        for (int k = 4; k <= 11; k++) begin
            check($sformatf("s6_rst_nowb_c%0d", k), 32'(bus.wb_valid), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
